// File: rtl/bullet_renderer.sv
// Bullet row renderer for the VGA adapter.
// On each accepted frame tick the row bitmap and row position are
// snapshotted, the previous frame's bullets are erased (skipping pixels
// that will be redrawn in place), the new bullets are drawn, and the
// snapshot becomes the reference for the next frame's erase pass.
module bullet_renderer #(
    parameter int unsigned COLS          = 160,
    parameter logic [2:0]  BULLET_COLOUR = 3'b111,
    parameter logic [2:0]  BG_COLOUR     = 3'b000
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            frame_tick,
    input  logic [COLS-1:0] bullets,
    input  logic [6:0]      row_y,
    output logic [7:0]      x_out,
    output logic [6:0]      y_out,
    output logic [2:0]      colour,
    output logic            plot,
    output logic            busy,
    output logic            done
);

    typedef enum logic [1:0] {
        IDLE,
        ERASE,
        DRAW,
        FINISH
    } state_t;

    localparam logic [7:0] LAST_COL = 8'(COLS - 1);

    state_t          state_q, state_d;
    logic [7:0]      col_q, col_d;
    logic [COLS-1:0] cur_map_q, cur_map_d;
    logic [COLS-1:0] prev_map_q, prev_map_d;
    logic [6:0]      cur_y_q, cur_y_d;
    logic [6:0]      prev_y_q, prev_y_d;
    logic [7:0]      x_q, x_d;
    logic [6:0]      y_q, y_d;
    logic [2:0]      colour_q, colour_d;
    logic            plot_q, plot_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;

    // A previous bullet is left alone when the same column is lit again
    // on the same row: erasing it would only cause a one-frame flicker.
    logic erase_hit;
    logic draw_hit;

    // Per-column plot decisions for the column currently being visited.
    always_comb begin
        erase_hit = prev_map_q[col_q] && !(cur_map_q[col_q] && (cur_y_q == prev_y_q));
        draw_hit  = cur_map_q[col_q];
    end

    // Next-state, column sweep and registered plot outputs.
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        cur_map_d  = cur_map_q;
        prev_map_d = prev_map_q;
        cur_y_d    = cur_y_q;
        prev_y_d   = prev_y_q;
        x_d        = x_q;
        y_d        = y_q;
        colour_d   = colour_q;
        plot_d     = 1'b0;
        done_d     = 1'b0;
        // Outputs lag the state by one cycle, so busy mirrors the state
        // being acted on this cycle and stays aligned with plot and done.
        busy_d     = (state_q != IDLE);

        unique case (state_q)
            IDLE: begin
                if (frame_tick) begin
                    cur_map_d = bullets;
                    cur_y_d   = row_y;
                    col_d     = '0;
                    state_d   = ERASE;
                end
            end

            ERASE: begin
                if (erase_hit) begin
                    plot_d   = 1'b1;
                    x_d      = col_q;
                    y_d      = prev_y_q;
                    colour_d = BG_COLOUR;
                end
                if (col_q == LAST_COL) begin
                    col_d   = '0;
                    state_d = DRAW;
                end else begin
                    col_d = col_q + 8'd1;
                end
            end

            DRAW: begin
                if (draw_hit) begin
                    plot_d   = 1'b1;
                    x_d      = col_q;
                    y_d      = cur_y_q;
                    colour_d = BULLET_COLOUR;
                end
                if (col_q == LAST_COL) begin
                    col_d   = '0;
                    state_d = FINISH;
                end else begin
                    col_d = col_q + 8'd1;
                end
            end

            FINISH: begin
                done_d     = 1'b1;
                prev_map_d = cur_map_q;
                prev_y_d   = cur_y_q;
                state_d    = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            col_q      <= '0;
            cur_map_q  <= '0;
            prev_map_q <= '0;
            cur_y_q    <= '0;
            prev_y_q   <= '0;
            x_q        <= '0;
            y_q        <= '0;
            colour_q   <= BG_COLOUR;
            plot_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            col_q      <= col_d;
            cur_map_q  <= cur_map_d;
            prev_map_q <= prev_map_d;
            cur_y_q    <= cur_y_d;
            prev_y_q   <= prev_y_d;
            x_q        <= x_d;
            y_q        <= y_d;
            colour_q   <= colour_d;
            plot_q     <= plot_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign x_out  = x_q;
    assign y_out  = y_q;
    assign colour = colour_q;
    assign plot   = plot_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_bullet_renderer.sv
// Self-checking bench for bullet_renderer: every cycle of each frame is
// compared against a per-frame pixel model derived from the erase/draw
// rules and the documented latency (offset 1+k erase, 1+COLS+k draw,
// 1+2*COLS done).
module tb_bullet_renderer;

    localparam int COLS = 160;
    localparam logic [2:0] BULLET_C = 3'b111;
    localparam logic [2:0] BG_C     = 3'b000;

    logic            clock;
    logic            reset_n;
    logic            frame_tick;
    logic [COLS-1:0] bullets;
    logic [6:0]      row_y;
    logic [7:0]      x_out;
    logic [6:0]      y_out;
    logic [2:0]      colour;
    logic            plot;
    logic            busy;
    logic            done;

    int compared   = 0;
    int mismatched = 0;

    // model state
    logic [COLS-1:0] m_prev_map;
    logic [6:0]      m_prev_y;
    logic [7:0]      m_last_x;
    logic [6:0]      m_last_y;
    logic [2:0]      m_last_c;

    bullet_renderer #(
        .COLS(COLS),
        .BULLET_COLOUR(BULLET_C),
        .BG_COLOUR(BG_C)
    ) dut (
        .clock(clock),
        .reset_n(reset_n),
        .frame_tick(frame_tick),
        .bullets(bullets),
        .row_y(row_y),
        .x_out(x_out),
        .y_out(y_out),
        .colour(colour),
        .plot(plot),
        .busy(busy),
        .done(done)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no end, required completion");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [COLS-1:0] rand_map();
        logic [COLS-1:0] m;
        for (int i = 0; i < COLS; i++) m[i] = ($urandom_range(0, 3) == 0);
        return m;
    endfunction

    function automatic logic [20:0] observed();
        return {plot, x_out, y_out, colour, busy, done};
    endfunction

    // One full frame: tick at edge T, then every cycle T+1..T+2*COLS+1 is
    // checked. xa/xb are offsets at which extra ticks are driven, rst_at
    // the offset at which reset is sampled low (0 = none).
    task automatic run_frame(input logic [COLS-1:0] map, input logic [6:0] y,
                             input bit scramble, input int xa, input int xb,
                             input int rst_at, input string name);
        logic [COLS-1:0] cm;
        logic [6:0]      cy;
        logic            e_plot, e_done;
        logic [20:0]     exp_v, got_v;
        int              k;
        cm = map;
        cy = y;
        @(negedge clock);
        frame_tick = 1'b1;
        bullets    = map;
        row_y      = y;
        @(posedge clock);
        for (int o = 1; o <= 2 * COLS + 1; o++) begin
            @(negedge clock);
            frame_tick = (o == xa) || (o == xb);
            if (scramble) begin
                bullets = rand_map();
                row_y   = 7'($urandom);
            end
            if (o == rst_at) reset_n = 1'b0;
            @(posedge clock);
            #1;
            if (o == rst_at) begin
                m_prev_map = '0;
                m_prev_y   = '0;
                m_last_x   = '0;
                m_last_y   = '0;
                m_last_c   = BG_C;
                exp_v = {1'b0, 8'd0, 7'd0, BG_C, 1'b0, 1'b0};
                got_v = observed();
                compared++;
                if (got_v !== exp_v) begin
                    mismatched++;
                    $display("FAIL %s reset@%0d: got %h required %h", name, o, got_v, exp_v);
                end
                @(negedge clock);
                reset_n    = 1'b1;
                frame_tick = 1'b0;
                return;
            end
            e_plot = 1'b0;
            e_done = 1'b0;
            if (o <= COLS) begin
                k = o - 1;
                if (m_prev_map[k] && !(cm[k] && cy == m_prev_y)) begin
                    e_plot   = 1'b1;
                    m_last_x = 8'(k);
                    m_last_y = m_prev_y;
                    m_last_c = BG_C;
                end
            end else if (o <= 2 * COLS) begin
                k = o - 1 - COLS;
                if (cm[k]) begin
                    e_plot   = 1'b1;
                    m_last_x = 8'(k);
                    m_last_y = cy;
                    m_last_c = BULLET_C;
                end
            end else begin
                e_done = 1'b1;
            end
            exp_v = {e_plot, m_last_x, m_last_y, m_last_c, 1'b1, e_done};
            got_v = observed();
            compared++;
            if (got_v !== exp_v) begin
                mismatched++;
                $display("FAIL %s offset %0d: got {plot,x,y,c,busy,done}=%h required %h",
                         name, o, got_v, exp_v);
            end
        end
        m_prev_map = cm;
        m_prev_y   = cy;
    endtask

    task automatic check_idle(input int cycles, input string name);
        logic [20:0] exp_v, got_v;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clock);
            frame_tick = 1'b0;
            @(posedge clock);
            #1;
            exp_v = {1'b0, m_last_x, m_last_y, m_last_c, 1'b0, 1'b0};
            got_v = observed();
            compared++;
            if (got_v !== exp_v) begin
                mismatched++;
                $display("FAIL %s cycle %0d: got %h required %h", name, i, got_v, exp_v);
            end
        end
    endtask

    task automatic test_reset();
        logic [20:0] exp_v, got_v;
        reset_n    = 1'b0;
        frame_tick = 1'b1;
        bullets    = rand_map();
        row_y      = 7'd42;
        repeat (3) @(posedge clock);
        #1;
        exp_v = {1'b0, 8'd0, 7'd0, BG_C, 1'b0, 1'b0};
        got_v = observed();
        compared++;
        if (got_v !== exp_v) begin
            mismatched++;
            $display("FAIL reset_state: got %h required %h", got_v, exp_v);
        end
        m_prev_map = '0;
        m_prev_y   = '0;
        m_last_x   = '0;
        m_last_y   = '0;
        m_last_c   = BG_C;
        @(negedge clock);
        reset_n    = 1'b1;
        frame_tick = 1'b0;
        check_idle(4, "idle_after_reset");
    endtask

    task automatic test_spec_frames();
        logic [COLS-1:0] m;
        m = '0;
        m[0] = 1'b1; m[5] = 1'b1; m[159] = 1'b1;
        run_frame(m, 7'd100, 1'b0, 0, 0, 0, "first_frame");
        m = '0;
        m[6] = 1'b1;
        run_frame(m, 7'd100, 1'b0, 0, 0, 0, "second_frame");
        run_frame(m, 7'd99, 1'b0, 0, 0, 0, "third_frame");
        check_idle(3, "idle_after_spec");
    endtask

    task automatic test_back_to_back();
        // extra ticks at T+10 and T+321 ignored; tick at T+322 accepted
        run_frame(rand_map(), 7'($urandom), 1'b0, 10, 2 * COLS + 1, 0, "ignored_ticks");
        run_frame(rand_map(), m_prev_y, 1'b0, 0, 0, 0, "back_to_back");
        check_idle(3, "idle_after_b2b");
    endtask

    task automatic test_mid_frame_reset();
        logic [COLS-1:0] m;
        m = rand_map();
        run_frame(m, 7'd17, 1'b0, 0, 0, 0, "pre_reset_frame");
        run_frame(m, 7'd18, 1'b0, 0, 0, 200, "mid_frame_reset");
        check_idle(2, "idle_after_abort");
        run_frame(m, 7'd18, 1'b0, 0, 0, 0, "post_reset_frame");
    endtask

    task automatic test_snapshot();
        run_frame(rand_map(), 7'd60, 1'b1, 0, 0, 0, "snapshot_a");
        run_frame(rand_map(), 7'd60, 1'b1, 0, 0, 0, "snapshot_b");
        check_idle(2, "idle_after_snapshot");
    endtask

    task automatic test_random_frames();
        logic [6:0] y;
        for (int n = 0; n < 4; n++) begin
            y = ($urandom_range(0, 1) == 0) ? m_prev_y : 7'($urandom);
            run_frame(rand_map(), y, 1'b0, 0, 0, 0, "random_frame");
            check_idle(int'($urandom_range(0, 2)), "random_gap");
        end
    endtask

    initial begin
        reset_n    = 1'b0;
        frame_tick = 1'b0;
        bullets    = '0;
        row_y      = '0;
        test_reset();
        test_spec_frames();
        test_back_to_back();
        test_mid_frame_reset();
        test_snapshot();
        test_random_frames();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
